// File: rtl/gol_ctrl_if.sv
// Handshake bundle between the Game of Life controller and its datapath/buttons.
// master drives buttons and the grid; slave is the controller.
interface gol_ctrl_if #(
    parameter int unsigned GEN_W = 16
) ();
    logic             btn_start;
    logic             btn_pause;
    logic             btn_stop;
    logic             btn0;
    logic             btn1;
    logic [48:0]      grid;
    logic [1:0]       state;
    logic             stop;
    logic             cell_wr;
    logic             cell_val;
    logic [5:0]       prog_idx;
    logic             calc;
    logic             commit;
    logic [GEN_W-1:0] gen_count;
    logic             stable;

    modport master (
        output btn_start, btn_pause, btn_stop, btn0, btn1, grid,
        input  state, stop, cell_wr, cell_val, prog_idx, calc, commit, gen_count, stable
    );

    modport slave (
        input  btn_start, btn_pause, btn_stop, btn0, btn1, grid,
        output state, stop, cell_wr, cell_val, prog_idx, calc, commit, gen_count, stable
    );
endinterface

// File: rtl/gol_ctrl.sv
// Mode sequencer for the 7x7 Game of Life datapath: programming strobes, generation pacing.
// Define GOL_STILL_DETECT_EN to also halt (PAUSE, stable=1) when the grid stops changing.
module gol_ctrl #(
    parameter int unsigned GEN_PERIOD = 25_000_000,
    parameter int unsigned GEN_W      = 16
) (
    input logic       clka,
    input logic       rst_n,
    gol_ctrl_if.slave bus
);

    localparam int unsigned       TimerW   = (GEN_PERIOD > 2) ? $clog2(GEN_PERIOD) : 1;
    localparam logic [TimerW-1:0] TimerMax = TimerW'(GEN_PERIOD - 1);
    localparam logic [5:0]        LastIdx  = 6'd48;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StProgram = 2'b01,
        StRun     = 2'b10,
        StPause   = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        btn_prev_q, btn_cur, btn_edge;
    logic              stop_q, stop_d;
    logic              cell_wr_q, cell_wr_d;
    logic              cell_val_q, cell_val_d;
    logic [5:0]        prog_idx_q, prog_idx_d;
    logic              calc_q, calc_d;
    logic              commit_q, commit_d;
    logic              chk_q, chk_d;
    logic [GEN_W-1:0]  gen_count_q, gen_count_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              e_stop, e_pause, e_start, e_one, e_zero;
    logic              wr_req, extinct, still;
`ifdef GOL_STILL_DETECT_EN
    logic [48:0]       snap_q, snap_d;
    logic              stable_q, stable_d;
`endif

    always_comb begin
        btn_cur  = {bus.btn_stop, bus.btn_pause, bus.btn_start, bus.btn1, bus.btn0};
        btn_edge = btn_cur & ~btn_prev_q;
        {e_stop, e_pause, e_start, e_one, e_zero} = btn_edge;
        // A write needs exactly one data button; higher-priority edges mask it.
        wr_req  = ((e_zero & ~bus.btn1) | (e_one & ~bus.btn0)) & ~e_start & ~e_pause;
        extinct = chk_q && (bus.grid == '0);
`ifdef GOL_STILL_DETECT_EN
        still    = chk_q && (bus.grid == snap_q) && !extinct;
        snap_d   = calc_q ? bus.grid : snap_q;
        stable_d = stable_q;
`else
        still = 1'b0;
`endif
        state_d     = state_q;
        stop_d      = 1'b0;
        cell_wr_d   = 1'b0;
        cell_val_d  = cell_val_q;
        prog_idx_d  = prog_idx_q;
        calc_d      = 1'b0;
        commit_d    = calc_q;
        chk_d       = commit_q;
        gen_count_d = gen_count_q;
        timer_d     = timer_q;

        if (e_stop) begin
            state_d     = StIdle;
            stop_d      = 1'b1;
            prog_idx_d  = '0;
            gen_count_d = '0;
            timer_d     = '0;
            commit_d    = 1'b0;
            chk_d       = 1'b0;
`ifdef GOL_STILL_DETECT_EN
            stable_d    = 1'b0;
`endif
        end else begin
            if (commit_d && gen_count_q != '1) gen_count_d = gen_count_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (e_start && !e_pause) begin
                        state_d     = StProgram;
                        prog_idx_d  = '0;
                        gen_count_d = '0;
                        timer_d     = '0;
                    end
                end
                StProgram: begin
                    // The index advances the cycle after each write strobe.
                    if (cell_wr_q && prog_idx_q == LastIdx) begin
                        state_d = StRun;
                        timer_d = '0;
                    end else begin
                        if (cell_wr_q) prog_idx_d = prog_idx_q + 1'b1;
                        if (e_start && !e_pause) begin
                            state_d = StRun;
                            timer_d = '0;
                        end else if (wr_req) begin
                            cell_wr_d  = 1'b1;
                            cell_val_d = bus.btn1;
                        end
                    end
                end
                StRun: begin
                    if (extinct) begin
                        state_d = StIdle;
                    end else if (still) begin
                        state_d = StPause;
`ifdef GOL_STILL_DETECT_EN
                        stable_d = 1'b1;
`endif
                    end else if (e_pause) begin
                        state_d = StPause;
                    end else begin
                        calc_d  = (timer_q == TimerMax);
                        timer_d = calc_d ? '0 : timer_q + 1'b1;
                    end
                end
                StPause: begin
                    if (extinct) begin
                        state_d = StIdle;
`ifdef GOL_STILL_DETECT_EN
                        stable_d = 1'b0;
`endif
                    end else if (still) begin
`ifdef GOL_STILL_DETECT_EN
                        stable_d = 1'b1;
`endif
                    end else if (e_pause || e_start) begin
                        state_d = StRun;
                        timer_d = '0;
`ifdef GOL_STILL_DETECT_EN
                        stable_d = 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            btn_prev_q  <= '0;
            stop_q      <= 1'b0;
            cell_wr_q   <= 1'b0;
            cell_val_q  <= 1'b0;
            prog_idx_q  <= '0;
            calc_q      <= 1'b0;
            commit_q    <= 1'b0;
            chk_q       <= 1'b0;
            gen_count_q <= '0;
            timer_q     <= '0;
`ifdef GOL_STILL_DETECT_EN
            snap_q      <= '0;
            stable_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_cur;
            stop_q      <= stop_d;
            cell_wr_q   <= cell_wr_d;
            cell_val_q  <= cell_val_d;
            prog_idx_q  <= prog_idx_d;
            calc_q      <= calc_d;
            commit_q    <= commit_d;
            chk_q       <= chk_d;
            gen_count_q <= gen_count_d;
            timer_q     <= timer_d;
`ifdef GOL_STILL_DETECT_EN
            snap_q      <= snap_d;
            stable_q    <= stable_d;
`endif
        end
    end

    assign bus.state     = state_q;
    assign bus.stop      = stop_q;
    assign bus.cell_wr   = cell_wr_q;
    assign bus.cell_val  = cell_val_q;
    assign bus.prog_idx  = prog_idx_q;
    assign bus.calc      = calc_q;
    assign bus.commit    = commit_q;
    assign bus.gen_count = gen_count_q;
`ifdef GOL_STILL_DETECT_EN
    assign bus.stable    = stable_q;
`else
    assign bus.stable    = 1'b0;
`endif

endmodule

// File: doc/gol_ctrl.md
# gol_ctrl

Sequencing controller for the 7x7 Game of Life datapath. Owns the IDLE/PROGRAM/RUN/PAUSE mode, turns button edges into one-cycle cell-write strobes while programming, and paces generations in RUN with calc/commit pulses at a fixed period. Watches the 49-bit grid returned by the datapath to detect extinction and, optionally, still life.

## Interface
- GEN_PERIOD, 25_000_000: clock cycles per generation in RUN; legal range ≥ 2.
- GEN_W, 16: width of the generation counter.

Ports:
- clka  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_start  in  1  start/resume level, already debounced and synchronous.
- btn_pause  in  1  pause/resume toggle level.
- btn_stop  in  1  abort level.
- btn0  in  1  program a dead cell.
- btn1  in  1  program a live cell.
- grid  in  49  current datapath grid, bit 7*row+col.
- state  out  2  00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- stop  out  1  one-cycle datapath clear pulse.
- cell_wr  out  1  one-cycle program-write strobe.
- cell_val  out  1  value to write, valid with cell_wr.
- prog_idx  out  6  cell index for cell_wr, 0..48.
- calc  out  1  one-cycle "compute next generation" pulse.
- commit  out  1  one-cycle "latch new grid" pulse.
- gen_count  out  GEN_W  generations committed since last start.
- stable  out  1  halted on still life; only with GOL_STILL_DETECT_EN.

## Operation
- **Edge detection:** registered previous value per button. An edge is cur=1 & prev=0. Only edges act; held levels do nothing.
- **Edge priority:** stop > pause > start > btn0/btn1.
- **Stop edge, any state:**
  - state→IDLE, stop=1 for one cycle.
  - prog_idx, gen_count, timer and stable cleared.
- **IDLE:** start edge → PROGRAM, prog_idx=0.
- **PROGRAM:**
  - An edge on exactly one of btn0/btn1 (the other low) → cell_wr=1, cell_val=btn1, at the current prog_idx.
  - prog_idx increments the following cycle.
  - Simultaneous btn0 and btn1 edges are ignored.
  - Write with prog_idx=48 → RUN next cycle; prog_idx holds 48 (no wrap).
  - Start edge → RUN early; unwritten cells stay as the datapath holds them.
- **RUN:**
  - Timer counts 0..GEN_PERIOD-1, then wraps.
  - calc=1 when timer==GEN_PERIOD-1.
  - commit=1 on the next cycle (timer==0 after wrap).
  - gen_count increments on commit, saturating at all-ones.
- **Extinction:** in the cycle after commit, grid==0 → IDLE; gen_count is retained.
- **Pause:** pause edge in RUN → PAUSE.
  - A calc already issued still gets its commit.
  - The timer freezes after that commit.
- **PAUSE:** pause or start edge → RUN, timer restarts at 0.
- Pause/start edges in states not listed are ignored.

## Timing
- **Reset values:** state=00 and every other output 0; timer 0, prev-button registers 0.
- **Reset mid-run:** reset aborts immediately; no trailing commit.
- **Input-to-output latency:**
  - Button edge sampled in cycle N → state/strobe outputs change at edge N+1.
  - cell_wr is exactly 1 cycle wide.
- **RUN pacing:**
  - First calc is GEN_PERIOD cycles after RUN entry.
  - calc→commit spacing is exactly 1 cycle.
  - calc and commit are never high together.
  - calc/commit period is GEN_PERIOD.
- **Extinction/stable check:** grid sampled 1 cycle after commit; transition visible 2 cycles after commit.
- **Stop edge together with a pending commit:** stop wins; commit is suppressed.

## Configuration
- **GOL_STILL_DETECT_EN defined:**
  - 49-bit snapshot of grid taken on each calc.
  - In the cycle after commit, grid==snapshot and grid!=0 → PAUSE with stable=1.
  - stable clears on leaving PAUSE, or on stop.
- **GOL_STILL_DETECT_EN undefined:**
  - No snapshot register, and stable is tied 0.
  - Still lifes keep running.

## Test plan
- **Programming:** reset; start edge; 49 edges alternating btn1/btn0.
  - Expect cell_wr with prog_idx 0..48 and cell_val 1,0,1,….
  - Expect state=10 one cycle after the 49th write.
- **RUN pacing:** GEN_PERIOD=4, grid held as a blinker.
  - calc every 4 cycles, commit 1 cycle later.
  - gen_count=3 after 3 commits; state stays 10.
- **Extinction:** grid driven to 0 after a commit → state=00 two cycles after commit; gen_count retained.
- **Pause/resume:** pause edge on the calc cycle.
  - Commit still issued, then state=11 and the timer frozen.
  - Second pause edge → RUN; next calc after GEN_PERIOD cycles.
- **Stop and reset:** stop edge mid-PROGRAM at prog_idx=20, then rst_n low mid-RUN.
  - Stop gives a 1-cycle stop pulse and state=00.
  - Reset makes all outputs 0 asynchronously.
- **Still life (macro on):** grid held at a 2x2 block across a calc/commit → state=11, stable=1; start edge → stable=0.
